line_fill_arbiter: RTL and testbench

- Sits directly downstream of the instruction cache and data cache inside the Memory block.
- Arbitrates line-fill reads from both caches and line writebacks from the data cache onto one word-wide backing RAM.
- Models main-memory latency with a programmable delay, then streams 8-word lines word-by-word.
- Replaces the per-cache private access path to main memory.

---
 rtl/line_fill_arbiter.sv | 171 +++++++++++++++++
 tb/tb_line_fill_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_arbiter.sv
// Round-robin arbiter that puts I/D line fills and D writebacks onto one word-wide RAM.
// Optional build macro CRITICAL_WORD_FIRST_EN: read fills start at the requested word and wrap.
module line_fill_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int DELAY_BITS     = 3
) (
  input  logic                  MEM_CLK,
  input  logic                  RST,
  input  logic                  I_REQ,
  input  logic [ADDR_WIDTH-6:0] I_LINE_ADDR,
  input  logic [2:0]            I_WORD,
  output logic                  I_WORD_VALID,
  output logic [2:0]            I_WORD_IDX,
  output logic                  I_DONE,
  input  logic                  D_REQ,
  input  logic                  D_WE,
  input  logic [ADDR_WIDTH-6:0] D_LINE_ADDR,
  input  logic [2:0]            D_WORD,
  input  logic [31:0]           D_WDATA,
  output logic                  D_WORD_VALID,
  output logic [2:0]            D_WORD_IDX,
  output logic                  D_DONE,
  output logic [31:0]           RDATA,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-3:0] RAM_ADDR,
  output logic [31:0]           RAM_WDATA,
  input  logic [31:0]           RAM_RDATA
);

  localparam int                    LINE_W    = ADDR_WIDTH - 5;
  localparam logic [2:0]            LAST_WORD = 3'(WORDS_PER_LINE - 1);
  localparam logic [DELAY_BITS-1:0] WAIT_LAST = {DELAY_BITS{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_XFER  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DELAY_BITS-1:0] r_cnt;
  logic [2:0]            r_k;
  logic [2:0]            r_rd_idx;
  logic [2:0]            w_idx;
  logic                  r_owner_d;
  logic                  r_we;
  logic                  r_last_d;
  logic                  r_rd_valid;
  logic [LINE_W-1:0]     r_line;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_xfer;

  // Round-robin: on a tie the side that did not win last time goes first.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant_d = D_REQ & (~I_REQ | ~r_last_d);
      w_grant_i = I_REQ & ~w_grant_d;
    end else begin
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  logic [2:0] r_start;

  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      r_start <= 3'd0;
    end else if (w_grant_d) begin
      r_start <= D_WORD;
    end else if (w_grant_i) begin
      r_start <= I_WORD;
    end else begin
      r_start <= r_start;
    end
  end

  // Writebacks always stream in natural order; only fills rotate.
  always_comb begin
    if (r_we) begin
      w_idx = r_k;
    end else begin
      w_idx = r_start + r_k;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{I_WORD, D_WORD};
  assign w_idx    = r_k;
`endif

  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (w_grant_i | w_grant_d) ? S_WAIT : S_IDLE;
      S_WAIT:  w_next = (r_cnt == WAIT_LAST) ? S_XFER : S_WAIT;
      S_XFER:  w_next = (r_k != LAST_WORD) ? S_XFER : (r_we ? S_IDLE : S_DRAIN);
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Owner capture at grant; inputs are ignored afterwards until the operation ends.
  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      r_k        <= 3'd0;
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_last_d   <= 1'b1;
      r_line     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_idx   <= 3'd0;
    end else begin
      r_rd_valid <= (r_state == S_XFER) & ~r_we;
      r_rd_idx   <= w_idx;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_k   <= 3'd0;
          if (w_grant_d) begin
            r_owner_d <= 1'b1;
            r_we      <= D_WE;
            r_line    <= D_LINE_ADDR;
            r_last_d  <= 1'b1;
          end else if (w_grant_i) begin
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_line    <= I_LINE_ADDR;
            r_last_d  <= 1'b0;
          end
        end
        S_WAIT:  r_cnt <= r_cnt + DELAY_BITS'(1);
        S_XFER:  r_k   <= r_k + 3'd1;
        default: r_k   <= r_k;
      endcase
    end
  end

  always_comb begin
    w_xfer       = (r_state == S_XFER);
    RAM_EN       = w_xfer;
    RAM_WE       = w_xfer & r_we;
    RAM_ADDR     = w_xfer ? {r_line, w_idx} : '0;
    RAM_WDATA    = D_WDATA;
    RDATA        = RAM_RDATA;
    I_WORD_VALID = r_rd_valid & ~r_owner_d;
    I_WORD_IDX   = (r_rd_valid & ~r_owner_d) ? r_rd_idx : 3'd0;
    I_DONE       = (r_state == S_DRAIN) & ~r_owner_d;
    D_WORD_VALID = r_owner_d & (r_rd_valid | (w_xfer & r_we));
    D_WORD_IDX   = (w_xfer & r_we) ? w_idx : ((r_owner_d & r_rd_valid) ? r_rd_idx : 3'd0);
    D_DONE       = r_owner_d & ((r_state == S_DRAIN) | (w_xfer & r_we & (r_k == LAST_WORD)));
  end

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Randomized bench for line_fill_arbiter: a transaction-timeline reference model predicts
// every cycle's outputs from grant time, operation type and the word ordering rule.
module tb_line_fill_arbiter;

  localparam int RAM_WORDS = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [10:0] i_line = 11'd0;
  logic [2:0]  i_word = 3'd0;
  logic        i_word_valid, i_done;
  logic [2:0]  i_word_idx;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [10:0] d_line = 11'd0;
  logic [2:0]  d_word = 3'd0;
  logic [31:0] d_wdata;
  logic        d_word_valid, d_done;
  logic [2:0]  d_word_idx;
  logic [31:0] rdata;
  logic        ram_en, ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'd0;
  logic [31:0] wb_seed = 32'd0;

  always #5 clk = ~clk;

  // Writeback source answers combinationally to the word index the arbiter asks for.
  assign d_wdata = wb_seed + {29'd0, d_word_idx} + 32'd1;

  line_fill_arbiter #(.ADDR_WIDTH(16), .WORDS_PER_LINE(8), .DELAY_BITS(3)) dut (
    .MEM_CLK(clk), .RST(rst),
    .I_REQ(i_req), .I_LINE_ADDR(i_line), .I_WORD(i_word),
    .I_WORD_VALID(i_word_valid), .I_WORD_IDX(i_word_idx), .I_DONE(i_done),
    .D_REQ(d_req), .D_WE(d_we), .D_LINE_ADDR(d_line), .D_WORD(d_word), .D_WDATA(d_wdata),
    .D_WORD_VALID(d_word_valid), .D_WORD_IDX(d_word_idx), .D_DONE(d_done),
    .RDATA(rdata), .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_ADDR(ram_addr),
    .RAM_WDATA(ram_wdata), .RAM_RDATA(ram_rdata)
  );

  function automatic logic [31:0] init_word(input int a);
    return 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Backing RAM: one-cycle registered read.
  logic [31:0] ram [0:RAM_WORDS-1];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int a = 0; a < RAM_WORDS; a++) ram[a] <= init_word(a);
      ram_ready <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int mc    = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, mc, obs, exp);
    end
  endtask

  function automatic logic [2:0] word_at(input bit we, input logic [2:0] start, input int k);
`ifdef CRITICAL_WORD_FIRST_EN
    if (!we) return 3'((int'(start) + k) % 8);
`endif
    return 3'(k);
  endfunction

  // Reference model state: one transaction timeline anchored at its grant cycle.
  logic [31:0] ref_mem [0:RAM_WORDS-1];
  bit          armed = 1'b0;
  bit          have_txn = 1'b0;
  bit          t_d, t_we, last_d = 1'b1;
  logic [10:0] t_line;
  logic [2:0]  t_start;
  logic [31:0] t_seed;
  int          t_g, t = 0, free_cyc = 0;
  bit          i_done_seen = 1'b0, d_done_seen = 1'b0;

  bit          e_en, e_we, e_iv, e_idn, e_dv, e_ddn, rd_chk;
  logic [13:0] e_addr;
  logic [31:0] e_wd, e_rd;
  logic [2:0]  e_ii, e_di, e_idx;

  initial begin
    for (int a = 0; a < RAM_WORDS; a++) ref_mem[a] = init_word(a);
    forever begin
      @(negedge clk);
      i_done_seen = i_done;
      d_done_seen = d_done;
      {e_en, e_we, e_iv, e_idn, e_dv, e_ddn, rd_chk} = 7'd0;
      e_addr = 14'd0; e_wd = 32'd0; e_rd = 32'd0; e_ii = 3'd0; e_di = 3'd0;
      if (have_txn) begin
        t = mc - t_g;
        // Wait window is grant+1..grant+8, then 8 issue cycles.
        if (t >= 9 && t <= 16) begin
          e_en   = 1'b1;
          e_we   = t_we;
          e_addr = {t_line, word_at(t_we, t_start, t - 9)};
        end
        if (t_we) begin
          if (t >= 9 && t <= 16) begin
            e_dv  = 1'b1;
            e_di  = word_at(1'b1, t_start, t - 9);
            e_wd  = t_seed + 32'(t - 9) + 32'd1;
            e_ddn = (t == 16);
          end
        end else if (t >= 10 && t <= 17) begin
          e_idx  = word_at(1'b0, t_start, t - 10);
          rd_chk = 1'b1;
          e_rd   = ref_mem[{t_line, e_idx}];
          if (t_d) begin
            e_dv = 1'b1; e_di = e_idx; e_ddn = (t == 17);
          end else begin
            e_iv = 1'b1; e_ii = e_idx; e_idn = (t == 17);
          end
        end
      end
      if (armed) begin
        check_eq("ram_en", ram_en, e_en);
        check_eq("ram_we", ram_we, e_we);
        check_eq("i_valid", i_word_valid, e_iv);
        check_eq("i_done", i_done, e_idn);
        check_eq("d_valid", d_word_valid, e_dv);
        check_eq("d_done", d_done, e_ddn);
        if (e_en) check_eq("ram_addr", ram_addr, e_addr);
        if (e_we) check_eq("ram_wdata", ram_wdata, e_wd);
        if (e_iv) check_eq("i_idx", i_word_idx, e_ii);
        if (e_dv) check_eq("d_idx", d_word_idx, e_di);
        if (rd_chk) check_eq("rdata", rdata, e_rd);
      end
      if (e_we) ref_mem[e_addr] = e_wd;
      if (rst) begin
        armed = 1'b1; have_txn = 1'b0; last_d = 1'b1; free_cyc = mc + 1;
      end else if (have_txn && ((t_we && t == 16) || (!t_we && t == 17))) begin
        have_txn = 1'b0; free_cyc = mc + 1;
      end else if (!have_txn && mc >= free_cyc && (i_req || d_req)) begin
        have_txn = 1'b1;
        t_g      = mc;
        t_d      = d_req && (!i_req || !last_d);
        last_d   = t_d;
        t_we     = t_d ? d_we : 1'b0;
        t_line   = t_d ? d_line : i_line;
        t_start  = t_d ? d_word : i_word;
        t_seed   = wb_seed;
      end
      mc++;
    end
  end

  typedef struct {
    bit          we;
    logic [10:0] line;
    logic [2:0]  word;
    logic [31:0] seed;
    int          gap;
  } req_t;

  req_t iq[$];
  req_t dq[$];
  bit   i_act = 1'b0, d_act = 1'b0;
  bit   rst_plan = 1'b0;
  int   rst_hold = 3;
  int   i_gap = 0, d_gap = 0;

  // Requesters: hold REQ until DONE, drop or re-present on the DONE edge, scramble after grant.
  initial begin
    req_t r;
    forever begin
      @(posedge clk);
      #1;
      if (rst_hold > 0) begin
        rst = 1'b1; rst_hold--;
      end else if (rst_plan && have_txn && t_d && t_we && (mc - t_g == 11)) begin
        rst = 1'b1; rst_plan = 1'b0;
      end else begin
        rst = 1'b0;
      end
      if (rst) begin
        i_act = 1'b0; d_act = 1'b0; i_req = 1'b0; d_req = 1'b0;
      end else begin
        if (i_act && i_done_seen) begin i_act = 1'b0; i_req = 1'b0; end
        if (i_act && have_txn && !t_d) begin
          i_line = 11'($urandom); i_word = 3'($urandom);
        end
        if (!i_act && iq.size() > 0) begin
          if (i_gap >= iq[0].gap) begin
            r = iq.pop_front();
            i_req = 1'b1; i_line = r.line; i_word = r.word; i_act = 1'b1; i_gap = 0;
          end else begin
            i_gap++;
          end
        end
        if (d_act && d_done_seen) begin d_act = 1'b0; d_req = 1'b0; end
        if (d_act && have_txn && t_d) begin
          d_line = 11'($urandom); d_word = 3'($urandom); d_we = 1'($urandom);
        end
        if (!d_act && dq.size() > 0) begin
          if (d_gap >= dq[0].gap) begin
            r = dq.pop_front();
            d_req = 1'b1; d_we = r.we; d_line = r.line; d_word = r.word;
            wb_seed = r.seed; d_act = 1'b1; d_gap = 0;
          end else begin
            d_gap++;
          end
        end
      end
    end
  end

  task automatic push_i(input logic [10:0] line, input logic [2:0] word, input int gap);
    iq.push_back('{we: 1'b0, line: line, word: word, seed: 32'd0, gap: gap});
  endtask

  task automatic push_d(input bit we, input logic [10:0] line, input logic [2:0] word,
                        input logic [31:0] seed, input int gap);
    dq.push_back('{we: we, line: line, word: word, seed: seed, gap: gap});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || i_act || d_act || have_txn) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("idle_wait", 64'(n < budget), 64'd1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (6) @(negedge clk);
    #1;
    check_eq("rst_ram_addr", ram_addr, 64'd0);
    check_eq("rst_i_idx", i_word_idx, 64'd0);
    check_eq("rst_d_idx", d_word_idx, 64'd0);
    check_eq("rst_ram_en", ram_en, 64'd0);

    push_i(11'h010, 3'd3, 0);
    wait_idle(200);

    push_d(1'b1, 11'h300, 3'd6, 32'd0, 0);
    wait_idle(200);
    for (int j = 0; j < 8; j++) check_eq("wb_ram_word", ram[14'h1800 + 14'(j)], 64'(j + 1));

    push_d(1'b0, 11'h300, 3'd5, 32'd0, 0);
    wait_idle(200);

    for (int rep = 0; rep < 2; rep++) begin
      push_i(11'h020 + 11'(rep), 3'd1, 0);
      push_d(1'b0, 11'h030 + 11'(rep), 3'd2, 32'd0, 0);
      wait_idle(400);
    end
    push_i(11'h040, 3'd0, 0);
    wait_idle(200);
    push_i(11'h041, 3'd4, 0);
    push_d(1'b1, 11'h042, 3'd0, 32'hA000_0000, 0);
    wait_idle(400);

    rst_plan = 1'b1;
    push_d(1'b1, 11'h050, 3'd0, 32'hB000_0000, 0);
    wait_idle(200);
    check_eq("rst_plan_used", 64'(rst_plan), 64'd0);
    push_i(11'h050, 3'd7, 0);
    wait_idle(200);

    push_d(1'b0, 11'h060, 3'd3, 32'd0, 0);
    push_d(1'b0, 11'h061, 3'd6, 32'd0, 0);
    wait_idle(400);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0)
        push_i(11'h100 + 11'($urandom_range(0, 15)), 3'($urandom), $urandom_range(0, 3));
      else
        push_d(1'($urandom_range(0, 9) < 6), 11'h100 + 11'($urandom_range(0, 15)),
               3'($urandom), $urandom, $urandom_range(0, 3));
    end
    wait_idle(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
